kyber_in_packer: RTL

Host-side loader for the Kyber input BRAM: accepts a 32-bit word stream from the register/DMA side, packs four consecutive words into one 128-bit line, and writes the lines into the host-facing port of the 128-bit input BRAM that `kyber_wrapper` reads. Sits directly upstream of `kyber_wrapper`. It places each line at the mode-dependent offset the wrapper's READ state expects, and pulses `done` when the full operand set for the armed mode is in memory.

---
 rtl/kyber_in_packer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/kyber_in_packer.sv
// ============================================================================
//  Module   : kyber_in_packer
//  Purpose  : Packs a 32-bit host word stream into 128-bit lines and writes
//             them to the Kyber input BRAM at the mode-dependent line offset
//             that kyber_wrapper reads from.
//  Options  : KYBER_PACK_CHECKSUM_EN - enables the running XOR checksum of
//             accepted words; otherwise checksum is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kyber_in_packer #(
  parameter logic [7:0] BASE_KEYGEN = 8'd52,
  parameter logic [7:0] BASE_ENC    = 8'd0,
  parameter logic [7:0] BASE_DEC    = 8'd54
) (
  input  logic         reg_clk,
  input  logic         reg_rst,
  input  logic         arm,
  input  logic [1:0]   mode,
  input  logic         abort,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  output logic [7:0]   bram_addr,
  output logic         bram_en,
  output logic [15:0]  bram_we,
  output logic [127:0] bram_wrdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [7:0]   lines_written,
  output logic [31:0]  checksum
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t         state_q, state_d;

  logic [1:0]     word_idx_q;
  logic [7:0]     line_addr_q;
  logic [7:0]     target_q;
  logic [7:0]     lines_written_q;
  logic [95:0]    line_q;          // words 0..2 of the line being assembled
  logic [7:0]     bram_addr_q;
  logic           bram_en_q;
  logic [15:0]    bram_we_q;
  logic [127:0]   bram_wrdata_q;
  logic           done_q;
  logic           err_q;

  logic           w_start;
  logic           w_bad_arm;
  logic           w_hs;
  logic           w_last;
  logic [7:0]     w_base;
  logic [7:0]     w_target;

  // Per-mode first line and number of lines to fill.
  always_comb begin
    w_base   = BASE_DEC;
    w_target = 8'd96;
    case (mode)
      2'd0: begin w_base = BASE_KEYGEN; w_target = 8'd2;  end
      2'd1: begin w_base = BASE_ENC;    w_target = 8'd54; end
      default: begin w_base = BASE_DEC; w_target = 8'd96; end
    endcase
  end

  // Next-state logic: arm/abort handling and word handshakes.
  always_comb begin
    state_d   = state_q;
    w_start   = 1'b0;
    w_bad_arm = 1'b0;
    w_hs      = 1'b0;
    w_last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // abort in the same cycle suppresses the arm entirely
        if (arm && !abort) begin
          if (mode == 2'd3) begin
            w_bad_arm = 1'b1;
          end else begin
            w_start = 1'b1;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (s_valid) begin
          w_hs = 1'b1;
          if (word_idx_q == 2'd3 && lines_written_q == target_q - 8'd1) begin
            w_last  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Datapath: word packing, line write strobe and counters.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      word_idx_q      <= 2'd0;
      line_addr_q     <= 8'd0;
      target_q        <= 8'd0;
      lines_written_q <= 8'd0;
      line_q          <= 96'd0;
      bram_addr_q     <= 8'd0;
      bram_en_q       <= 1'b0;
      bram_we_q       <= 16'h0000;
      bram_wrdata_q   <= 128'd0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      bram_en_q <= 1'b0;
      bram_we_q <= 16'h0000;
      done_q    <= 1'b0;
      err_q     <= w_bad_arm;
      if (w_start) begin
        line_addr_q     <= w_base;
        target_q        <= w_target;
        word_idx_q      <= 2'd0;
        lines_written_q <= 8'd0;
      end
      if (w_hs) begin
        word_idx_q <= word_idx_q + 2'd1;
        case (word_idx_q)
          2'd0: line_q[31:0]  <= s_data;
          2'd1: line_q[63:32] <= s_data;
          2'd2: line_q[95:64] <= s_data;
          default: begin
            // fourth word completes the line: issue the write next cycle
            bram_en_q       <= 1'b1;
            bram_we_q       <= 16'hFFFF;
            bram_addr_q     <= line_addr_q;
            bram_wrdata_q   <= {s_data, line_q};
            line_addr_q     <= line_addr_q + 8'd1;
            lines_written_q <= lines_written_q + 8'd1;
            done_q          <= w_last;
          end
        endcase
      end
    end
  end

`ifdef KYBER_PACK_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running XOR of accepted words, restarted on each arm.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst)      checksum_q <= 32'd0;
    else if (w_start) checksum_q <= 32'd0;
    else if (w_hs)    checksum_q <= checksum_q ^ s_data;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

  assign s_ready       = (state_q == ST_FILL);
  assign busy          = (state_q == ST_FILL);
  assign bram_addr     = bram_addr_q;
  assign bram_en       = bram_en_q;
  assign bram_we       = bram_we_q;
  assign bram_wrdata   = bram_wrdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign lines_written = lines_written_q;

endmodule

`default_nettype wire
